// File: rtl/ee480_pkg.sv
// Shared constants and types for the EE480 16-bit core.
// Used by fetch_unit and fetch_pf_buf.
package ee480_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 10;
    localparam int unsigned OPC_W = OPC_HI - OPC_LO + 1;

    localparam logic [OPC_W-1:0] HALT_OPC = 6'b001111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        ISSUE,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_pf_buf.sv
// One-entry prefetch buffer (data, address, valid).
// Instantiated by fetch_unit only when FETCH_PREFETCH_EN is defined.
module fetch_pf_buf #(
    parameter int unsigned ADDR_W = ee480_pkg::ADDR_W,
    parameter int unsigned DATA_W = ee480_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] pf_data,
    output logic [ADDR_W-1:0] pf_addr,
    output logic              pf_valid
);

    // Flush beats load, load beats pop
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pf_data  <= '0;
            pf_addr  <= '0;
            pf_valid <= 1'b0;
        end else if (flush) begin
            pf_valid <= 1'b0;
        end else if (load) begin
            pf_data  <= ld_data;
            pf_addr  <= ld_addr;
            pf_valid <= 1'b1;
        end else if (pop) begin
            pf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, program memory read, IR to decode.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer.
module fetch_unit #(
    parameter int unsigned ADDR_W = ee480_pkg::ADDR_W,
    parameter int unsigned DATA_W = ee480_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ee480_pkg::OPC_W-1:0] HALT_OPC = ee480_pkg::HALT_OPC
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    output logic              mem_ce,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              halted
);

    import ee480_pkg::*;

    fetch_state_t state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic hs, is_halt, ir_ld, pc_inc, pc_br;

`ifdef FETCH_PREFETCH_EN
    logic ir_from_pf, pend, pend_nxt;
    logic pf_load, pf_pop, pf_flush, pf_valid;
    logic [DATA_W-1:0] pf_data;
    logic [ADDR_W-1:0] pf_addr;

    fetch_pf_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_pf_buf (
        .clk     (clk),
        .clr     (clr),
        .load    (pf_load),
        .pop     (pf_pop),
        .flush   (pf_flush),
        .ld_data (mem_data),
        .ld_addr (pc),
        .pf_data (pf_data),
        .pf_addr (pf_addr),
        .pf_valid(pf_valid)
    );
`endif

    assign hs       = (state == ISSUE) && ir_ready;
    assign is_halt  = ir_out[OPC_HI:OPC_LO] == HALT_OPC;
    assign ir_valid = state == ISSUE;
    assign halted   = state == HALT;
    assign mem_rw   = 1'b1;
    assign mem_addr = mem_ce ? pc : '0;

    // State register; reset drops mem_ce at once since it decodes state
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state, memory enable and datapath controls
    always_comb begin
        state_nxt = state;
        mem_ce    = 1'b0;
        ir_ld     = 1'b0;
        pc_inc    = 1'b0;
        pc_br     = 1'b0;
`ifdef FETCH_PREFETCH_EN
        ir_from_pf = 1'b0;
        pf_load    = 1'b0;
        pf_pop     = 1'b0;
        pf_flush   = 1'b0;
        pend_nxt   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                mem_ce = 1'b1;
                if (br_taken) pc_br = 1'b1;
                else          state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (br_taken) begin
                    pc_br     = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    ir_ld     = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (br_taken) begin
                    pc_br     = 1'b1;
                    state_nxt = FETCH;
`ifdef FETCH_PREFETCH_EN
                    pf_flush  = 1'b1;
`endif
                end else begin
`ifdef FETCH_PREFETCH_EN
                    // Word read last cycle lands in the buffer unless consumed directly
                    if (pend && !hs) begin
                        pf_load = 1'b1;
                        pc_inc  = 1'b1;
                    end
                    if (!pf_valid && !pend && !is_halt) mem_ce = 1'b1;
                    if (hs) begin
                        if (is_halt) begin
                            pf_flush  = 1'b1;
                            state_nxt = HALT;
                        end else if (pf_valid) begin
                            ir_ld      = 1'b1;
                            ir_from_pf = 1'b1;
                            pf_pop     = 1'b1;
                        end else if (pend) begin
                            ir_ld  = 1'b1;
                            pc_inc = 1'b1;
                        end else begin
                            state_nxt = CAPTURE;
                        end
                    end
                    pend_nxt = mem_ce && (state_nxt == ISSUE);
`else
                    if (hs) state_nxt = is_halt ? HALT : FETCH;
`endif
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef FETCH_PREFETCH_EN
    // Remembers a prefetch read whose data arrives this cycle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) pend <= 1'b0;
        else      pend <= pend_nxt;
    end
`endif

    // PC and instruction register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc     <= RESET_PC;
            ir_out <= '0;
            ir_pc  <= '0;
        end else begin
            if (pc_br)       pc <= br_target;
            else if (pc_inc) pc <= pc + ADDR_W'(1);
            if (ir_ld) begin
`ifdef FETCH_PREFETCH_EN
                ir_out <= ir_from_pf ? pf_data : mem_data;
                ir_pc  <= ir_from_pf ? pf_addr : pc;
`else
                ir_out <= mem_data;
                ir_pc  <= pc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (cycle table plus corner sequences).
// Expected values follow the build's FETCH_PREFETCH_EN setting.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic        run2 = 1'b0;
    logic        ir_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = '0;

    logic        mem_ce, mem_rw, ir_valid, halted;
    logic [7:0]  mem_addr, ir_pc;
    logic [15:0] mem_data, ir_out;

    logic        mem_ce2, mem_rw2, ir_valid2, halted2;
    logic [7:0]  mem_addr2, ir_pc2;
    logic [15:0] mem_data2, ir_out2;

    logic [15:0] mem  [256];
    logic [15:0] mem2 [256];

    int pass_cnt = 0;
    int tot_cnt = 0;

    typedef struct packed {
        logic        ce;
        logic [7:0]  addr;
        logic        vld;
        logic [15:0] ir;
        logic [7:0]  irpc;
        logic        hlt;
    } obs_t;

    typedef struct packed {
        logic       run;
        logic       rdy;
        logic       br;
        logic [7:0] tgt;
        obs_t       exp;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .clr(clr), .run(run),
        .mem_ce(mem_ce), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_data(mem_data), .ir_out(ir_out), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready),
        .br_taken(br_taken), .br_target(br_target), .halted(halted)
    );

    fetch_unit #(.RESET_PC(8'hFF)) dut2 (
        .clk(clk), .clr(clr), .run(run2),
        .mem_ce(mem_ce2), .mem_rw(mem_rw2), .mem_addr(mem_addr2),
        .mem_data(mem_data2), .ir_out(ir_out2), .ir_pc(ir_pc2),
        .ir_valid(ir_valid2), .ir_ready(ir_ready),
        .br_taken(br_taken), .br_target(br_target), .halted(halted2)
    );

    always @(posedge clk) begin
        if (mem_ce)  mem_data  <= mem[mem_addr];
        if (mem_ce2) mem_data2 <= mem2[mem_addr2];
    end

    function automatic obs_t get_obs();
        obs_t o;
        o.ce = mem_ce;
        o.addr = mem_addr;
        o.vld = ir_valid;
        o.ir = ir_out;
        o.irpc = ir_pc;
        o.hlt = halted;
        return o;
    endfunction

    function automatic vec_t mk(input logic ce, input logic [7:0] a,
                                input logic v, input logic [15:0] ir,
                                input logic [7:0] p, input logic h);
        vec_t r;
        r.run = 1'b1;
        r.rdy = 1'b1;
        r.br = 1'b0;
        r.tgt = '0;
        r.exp.ce = ce;
        r.exp.addr = a;
        r.exp.vld = v;
        r.exp.ir = ir;
        r.exp.irpc = p;
        r.exp.hlt = h;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_obs(input string nm, input obs_t act, input obs_t exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got ce=%b addr=%h vld=%b ir=%h pc=%h hlt=%b expected ce=%b addr=%h vld=%b ir=%h pc=%h hlt=%b",
                      nm, act.ce, act.addr, act.vld, act.ir, act.irpc, act.hlt,
                      exp.ce, exp.addr, exp.vld, exp.ir, exp.irpc, exp.hlt);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk(nm, 64'(get_obs()), 64'(0));
        chk({nm, "_rw"}, 64'(mem_rw), 64'(1));
    endtask

    task automatic do_reset(input string nm);
        run = 1'b0;
        run2 = 1'b0;
        ir_ready = 1'b0;
        br_taken = 1'b0;
        br_target = '0;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk_reset_vals(nm);
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic wait_valid(input string nm, input logic [15:0] ir, input logic [7:0] pc);
        int n = 0;
        while (!ir_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 64'(ir_valid), 64'(1));
        chk({nm, "_ir"}, 64'({ir_pc, ir_out}), 64'({pc, ir}));
    endtask

    task automatic expect_issue(input string nm, input logic [15:0] ir, input logic [7:0] pc);
        wait_valid(nm, ir, pc);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ce_cnt;
        int n;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0000;
            mem2[i] = 16'h0000;
        end
        mem[0] = 16'h3803;
        mem[1] = 16'h0005;
        mem[2] = 16'h0404;
        mem[3] = 16'h3C00;
        mem2[0] = 16'h3803;
        mem2[8'hFF] = 16'h1234;

`ifdef FETCH_PREFETCH_EN
        vt.push_back(mk(0, 8'h00, 0, 16'h0000, 8'h00, 0));
        vt.push_back(mk(1, 8'h00, 0, 16'h0000, 8'h00, 0));
        vt.push_back(mk(0, 8'h00, 0, 16'h0000, 8'h00, 0));
        vt.push_back(mk(1, 8'h01, 1, 16'h3803, 8'h00, 0));
        vt.push_back(mk(0, 8'h00, 0, 16'h3803, 8'h00, 0));
        vt.push_back(mk(1, 8'h02, 1, 16'h0005, 8'h01, 0));
        vt.push_back(mk(0, 8'h00, 0, 16'h0005, 8'h01, 0));
        vt.push_back(mk(1, 8'h03, 1, 16'h0404, 8'h02, 0));
        vt.push_back(mk(0, 8'h00, 0, 16'h0404, 8'h02, 0));
        vt.push_back(mk(0, 8'h00, 1, 16'h3C00, 8'h03, 0));
        vt.push_back(mk(0, 8'h00, 0, 16'h3C00, 8'h03, 1));
        vt.push_back(mk(0, 8'h00, 0, 16'h3C00, 8'h03, 1));
`else
        vt.push_back(mk(0, 8'h00, 0, 16'h0000, 8'h00, 0));
        vt.push_back(mk(1, 8'h00, 0, 16'h0000, 8'h00, 0));
        vt.push_back(mk(0, 8'h00, 0, 16'h0000, 8'h00, 0));
        vt.push_back(mk(0, 8'h00, 1, 16'h3803, 8'h00, 0));
        vt.push_back(mk(1, 8'h01, 0, 16'h3803, 8'h00, 0));
        vt.push_back(mk(0, 8'h00, 0, 16'h3803, 8'h00, 0));
        vt.push_back(mk(0, 8'h00, 1, 16'h0005, 8'h01, 0));
        vt.push_back(mk(1, 8'h02, 0, 16'h0005, 8'h01, 0));
        vt.push_back(mk(0, 8'h00, 0, 16'h0005, 8'h01, 0));
        vt.push_back(mk(0, 8'h00, 1, 16'h0404, 8'h02, 0));
        vt.push_back(mk(1, 8'h03, 0, 16'h0404, 8'h02, 0));
        vt.push_back(mk(0, 8'h00, 0, 16'h0404, 8'h02, 0));
        vt.push_back(mk(0, 8'h00, 1, 16'h3C00, 8'h03, 0));
        vt.push_back(mk(0, 8'h00, 0, 16'h3C00, 8'h03, 1));
        vt.push_back(mk(0, 8'h00, 0, 16'h3C00, 8'h03, 1));
`endif

        // Test 1: straight-line program to halt, cycle by cycle
        do_reset("t1_reset");
        foreach (vt[i]) begin
            run = vt[i].run;
            ir_ready = vt[i].rdy;
            br_taken = vt[i].br;
            br_target = vt[i].tgt;
            #1;
            chk_obs($sformatf("t1_row%0d", i), get_obs(), vt[i].exp);
            @(negedge clk);
        end

        // Test 2: decode stalls for 5 cycles on the first word
        do_reset("t2_reset");
        run = 1'b1;
        wait_valid("t2_first", 16'h3803, 8'h00);
        ce_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_ce) ce_cnt++;
            chk($sformatf("t2_stall%0d", k), 64'({ir_valid, ir_pc, ir_out}),
                64'({1'b1, 8'h00, 16'h3803}));
            @(negedge clk);
        end
`ifdef FETCH_PREFETCH_EN
        chk("t2_stall_reads", 64'(ce_cnt), 64'(1));
`else
        chk("t2_stall_reads", 64'(ce_cnt), 64'(0));
`endif
        ir_ready = 1'b1;
        expect_issue("t2_w0", 16'h3803, 8'h00);
        expect_issue("t2_w1", 16'h0005, 8'h01);
        expect_issue("t2_w2", 16'h0404, 8'h02);
        expect_issue("t2_w3", 16'h3C00, 8'h03);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2_halt%0d", k), 64'({halted, mem_ce, ir_valid}),
                64'({1'b1, 1'b0, 1'b0}));
            @(negedge clk);
        end

        // Test 3: redirect to 2 while word 0 is being captured
        do_reset("t3_reset");
        run = 1'b1;
        ir_ready = 1'b1;
        @(negedge clk);
        chk("t3_fetch0", 64'({mem_ce, mem_addr}), 64'({1'b1, 8'h00}));
        run = 1'b0;
        @(negedge clk);
        chk("t3_capture_invalid", 64'(ir_valid), 64'(0));
        br_taken = 1'b1;
        br_target = 8'h02;
        @(negedge clk);
        br_taken = 1'b0;
        chk("t3_refetch", 64'({ir_valid, mem_ce, mem_addr}), 64'({1'b0, 1'b1, 8'h02}));
        expect_issue("t3_w2", 16'h0404, 8'h02);
        expect_issue("t3_w3", 16'h3C00, 8'h03);
        chk("t3_halted", 64'(halted), 64'(1));

        // Test 4: PC wraps from 0xFF to 0x00
        do_reset("t4_reset");
        run2 = 1'b1;
        ir_ready = 1'b1;
        n = 0;
        while (!ir_valid2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_wFF", 64'({ir_valid2, ir_pc2, ir_out2}), 64'({1'b1, 8'hFF, 16'h1234}));
        @(negedge clk);
        n = 0;
        while (!ir_valid2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_w00", 64'({ir_valid2, ir_pc2, ir_out2}), 64'({1'b1, 8'h00, 16'h3803}));
        chk("t4_side", 64'({mem_rw2, halted2}), 64'({1'b1, 1'b0}));
        run2 = 1'b0;

        // Test 5: asynchronous clear during FETCH and during ISSUE
        do_reset("t5_reset");
        run = 1'b1;
        @(negedge clk);
        chk("t5_fetch", 64'({mem_ce, mem_addr}), 64'({1'b1, 8'h00}));
        #2;
        clr = 1'b0;
        #1;
        chk_reset_vals("t5_async_fetch");
        @(negedge clk);
        clr = 1'b1;
        run = 1'b1;
        ir_ready = 1'b0;
        wait_valid("t5_hold", 16'h3803, 8'h00);
        #2;
        clr = 1'b0;
        #1;
        chk_reset_vals("t5_async_issue");
        @(negedge clk);
        clr = 1'b1;
        ir_ready = 1'b1;
        expect_issue("t5_restart", 16'h3803, 8'h00);

        // Test 6: redirect in the same cycle as the halt handshake
        do_reset("t6_reset");
        run = 1'b1;
        ir_ready = 1'b1;
        expect_issue("t6_w0", 16'h3803, 8'h00);
        expect_issue("t6_w1", 16'h0005, 8'h01);
        expect_issue("t6_w2", 16'h0404, 8'h02);
        wait_valid("t6_w3", 16'h3C00, 8'h03);
        br_taken = 1'b1;
        br_target = 8'h01;
        @(negedge clk);
        br_taken = 1'b0;
        chk("t6_no_halt", 64'({halted, ir_valid}), 64'({1'b0, 1'b0}));
        expect_issue("t6_r1", 16'h0005, 8'h01);
        expect_issue("t6_r2", 16'h0404, 8'h02);
        expect_issue("t6_r3", 16'h3C00, 8'h03);
        chk("t6_halted", 64'({halted, mem_ce}), 64'({1'b1, 1'b0}));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
